dmem_resp: RTL
==============

Name: dmem_resp

Overview:
- Data-memory responder: the far end of the load/store unit's memory interface.
- Accepts one request at a time: word address, 4-bit byte-lane write enables, and lane-aligned write data.
- Stalls for a configurable number of wait states, commits writes per lane, and returns read data right-justified to the addressed byte. This lets the LSU's sign/zero extension use bits [15:0]/[7:0] directly.
- Sits between the LSU and the on-chip data RAM in the 2-stage core.

Parameters:
- DEPTH, 1024, memory size in 32-bit words; power of two.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; 4-byte aligned.
- WAIT_ST, 0, wait states inserted before response; range 0..15.

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- req  in  1  request valid; held by requester until ready
- data_addr  in  32  byte address of access
- dmem_wr  in  4  byte-lane write enables; 4'b0000 = read
- datamem_wr_in  in  32  write data, already rotated into byte lanes
- ready  out  1  one-cycle completion pulse
- datamem_rd_o  out  32  read data, shifted right by 8*data_addr[1:0], zero-filled
- err  out  1  out-of-range flag, valid with ready
- busy  out  1  request accepted and not yet completed

Behaviour:
- Reset (async, rstn=0): state=IDLE; ready=0, err=0, busy=0, datamem_rd_o=0; wait counter=0; captured request registers=0.
- Reset does not clear the memory array. A reset mid-operation aborts the access with no write committed.
- States: IDLE, WAIT, RESP.
- IDLE, req=1: capture data_addr, dmem_wr, datamem_wr_in; busy=1.
  - If WAIT_ST=0, go to RESP.
  - Otherwise go to WAIT with counter=WAIT_ST-1.
- WAIT: decrement counter each cycle; go to RESP when counter==0.
- RESP (one cycle): ready=1, busy=0; next state IDLE. req is not sampled in RESP.
- Latency: ready is asserted WAIT_ST+1 cycles after the accept edge. Throughput is one access per WAIT_ST+2 cycles.
- Range check: idx=(addr-BASE_ADDR)>>2. In range iff addr>=BASE_ADDR and idx<DEPTH. Computed on captured addr.
- Write (any dmem_wr bit set, in range): at the clock edge ending RESP, mem[idx][8k+7:8k] <= wr_data lane k for each set bit k. Unset lanes are unchanged.
- Read (dmem_wr=0, in range): datamem_rd_o <= mem[idx] >> (8*addr[1:0]), registered so it is valid in the RESP cycle. It holds until the next completed read.
- Write completion leaves datamem_rd_o unchanged.
- Out of range: no array access; err=1 with ready. A read returns datamem_rd_o=0.
- Mixed lane patterns (e.g. 4'b1000 with addr[1:0]=2'b11) are honoured as given; no alignment checking.
- req changes while busy are ignored. The captured request is fixed until completion.
- Simultaneous reset and RESP: reset wins; ready=0 and no write.

Decomposition:
- Shared package: state encoding (IDLE/WAIT/RESP) and a DMEM_RD constant (4'b0000) shared with the LSU.
- One sub-module, dmem_ram: DEPTH x 32 single-port RAM with 4 lane write enables and a synchronous registered read, no reset. The FSM, range check and read shifter live in dmem_resp.

Test Plan:
- WAIT_ST=0: write addr 0x10, dmem_wr=1111, data 0xDEADBEEF; then read 0x10 -> ready 1 cycle after each accept; read returns 0xDEADBEEF, err=0.
- Byte write: addr 0x12, dmem_wr=0100, data 0x00AB0000 over the above word; read 0x12 -> datamem_rd_o=0x0000DEAB; word at 0x10 reads 0xDEABBEEF.
- Halfword read at 0x11 of 0xDEABBEEF -> 0x00DEABBE; busy=1 only between accept and ready.
- WAIT_ST=3: read -> ready exactly 4 cycles after the accept edge; busy high for 4 cycles.
- Out of range: addr BASE_ADDR+4*DEPTH, write 0xFFFFFFFF then read same address -> err=1 with ready, datamem_rd_o=0; a neighbouring in-range word is unchanged.
- rstn pulsed low during WAIT of a write (WAIT_ST=3) -> outputs 0 immediately, no ready, target word keeps its old value; a following read returns the old value.

Source files
------------

// File: rtl/dmem_resp_pkg.sv
// dmem_resp_pkg: definitions shared by the data-memory responder and the LSU.
//   state_t   - responder FSM state encoding (IDLE / WAIT / RESP)
//   DMEM_RD   - byte-lane enable pattern that denotes a read access
//   align_rd  - right-justifies a memory word to the addressed byte
package dmem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] DMEM_RD = 4'b0000;

  // Shift a word right by whole bytes so the addressed byte lands in [7:0];
  // vacated upper bytes are zero-filled.
  function automatic logic [31:0] align_rd(input logic [31:0] word,
                                           input logic [1:0]  off);
    return word >> {off, 3'b000};
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: DEPTH x 32 single-port data RAM, no reset on contents.
//   clk   in   clock, rising edge
//   we    in   per-byte-lane write enables
//   rd_en in   load rdata from the addressed word on this edge
//   addr  in   word index
//   wdata in   lane-aligned write data
//   rdata out  registered read data; holds between rd_en pulses
module dmem_ram #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic [3:0]               we,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  // Each byte lane is its own array so lane enables map onto the RAM's
  // byte-write capability without read-modify-write.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    logic [7:0] rd_lane_reg;

    always_ff @(posedge clk) begin
      if (we[gi]) begin
        lane_mem[addr] <= wdata[8*gi +: 8];
      end
      if (rd_en) begin
        rd_lane_reg <= lane_mem[addr];
      end
    end

    assign rdata[8*gi +: 8] = rd_lane_reg;
  end

endmodule

// File: rtl/dmem_resp.sv
// dmem_resp: data-memory responder at the far end of the LSU memory port.
// Accepts one request at a time, inserts WAIT_ST wait states, commits
// lane-enabled writes and returns read data right-justified to the
// addressed byte.
//   clk           in   clock, rising edge
//   rstn          in   asynchronous active-low reset
//   req           in   request valid, held until ready
//   data_addr     in   byte address of the access
//   dmem_wr       in   byte-lane write enables, 4'b0000 = read
//   datamem_wr_in in   write data already rotated into byte lanes
//   ready         out  one-cycle completion pulse
//   datamem_rd_o  out  read data, shifted right by 8*addr[1:0], zero-filled
//   err           out  out-of-range flag, valid with ready
//   busy          out  request accepted and not yet completed
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          WAIT_ST   = 0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req,
  input  logic [31:0] data_addr,
  input  logic [3:0]  dmem_wr,
  input  logic [31:0] datamem_wr_in,
  output logic        ready,
  output logic [31:0] datamem_rd_o,
  output logic        err,
  output logic        busy
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'((WAIT_ST == 0) ? 0 : WAIT_ST - 1);

  state_t      state_reg;
  state_t      state_next;
  logic [3:0]  cnt_reg;
  logic [31:0] cap_addr_reg;
  logic [3:0]  cap_wr_reg;
  logic [31:0] cap_wdata_reg;
  logic [1:0]  rd_shift_reg;
  logic        rd_zero_reg;

  logic        accept;
  logic        to_resp;
  logic [31:0] cur_addr;
  logic [3:0]  cur_wr;
  logic [31:0] cur_off;
  logic        cur_in_range;
  logic        rd_issue;
  logic [3:0]  ram_we;
  logic [31:0] ram_rdata;

  assign accept = (state_reg == IDLE) && req;

  // With zero wait states the RAM read must be launched on the accept edge
  // itself, so the live request is used while idle; afterwards the
  // captured copy is the only source and late req-side changes are ignored.
  assign cur_addr = (state_reg == IDLE) ? data_addr : cap_addr_reg;
  assign cur_wr   = (state_reg == IDLE) ? dmem_wr   : cap_wr_reg;

  assign cur_off      = cur_addr - BASE_ADDR;
  assign cur_in_range = (cur_addr >= BASE_ADDR) && ((cur_off >> 2) < 32'(DEPTH));

  // The edge that enters RESP is the read edge, so data is valid in RESP.
  assign to_resp  = (state_next == RESP) && (state_reg != RESP);
  assign rd_issue = to_resp && (cur_wr == DMEM_RD) && cur_in_range;

  // Writes land on the edge that ends RESP; a reset in RESP forces IDLE
  // asynchronously, which drops the enables before that edge.
  assign ram_we = ((state_reg == RESP) && cur_in_range) ? cap_wr_reg : 4'b0000;

  dmem_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .rd_en (rd_issue),
    .addr  (cur_off[AW+1:2]),
    .wdata (cap_wdata_reg),
    .rdata (ram_rdata)
  );

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req) begin
          state_next = (WAIT_ST == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs. busy covers the accept cycle itself plus the wait states;
  // it is forced low while reset is asserted.
  always_comb begin
    ready = (state_reg == RESP);
    err   = (state_reg == RESP) && !cur_in_range;
    busy  = rstn && (accept || (state_reg == WAIT));
  end

  // Request capture, wait counter and read-result bookkeeping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cap_addr_reg  <= '0;
      cap_wr_reg    <= '0;
      cap_wdata_reg <= '0;
      cnt_reg       <= '0;
      rd_shift_reg  <= '0;
      rd_zero_reg   <= 1'b1;
    end else begin
      if (accept) begin
        cap_addr_reg  <= data_addr;
        cap_wr_reg    <= dmem_wr;
        cap_wdata_reg <= datamem_wr_in;
        cnt_reg       <= WAIT_INIT;
      end else if ((state_reg == WAIT) && (cnt_reg != 4'd0)) begin
        cnt_reg <= cnt_reg - 4'd1;
      end
      // Only a completing read updates the returned data; an out-of-range
      // read returns zero, writes leave the last read result in place.
      if (to_resp && (cur_wr == DMEM_RD)) begin
        rd_zero_reg  <= !cur_in_range;
        rd_shift_reg <= cur_addr[1:0];
      end
    end
  end

  // The RAM output register holds between reads, so shift amount and zero
  // flag registered alongside it give a stable, registered result.
  assign datamem_rd_o = rd_zero_reg ? 32'h0 : align_rd(ram_rdata, rd_shift_reg);

endmodule
